// File: rtl/serie_paralelo_rx.sv
// Receive-lane serial-to-parallel converter: hunts for the COMMA symbol to find
// byte alignment, locks after BC_REQ aligned COMMAs, then emits one byte per 8 clocks.
module serie_paralelo_rx #(
    parameter logic [7:0] COMMA  = 8'hBC,
    parameter logic [7:0] IDLE   = 8'h7C,
    parameter int         BC_REQ = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       data_inS,
    output logic [7:0] data_outP,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] BC_REQ_L = 4'(BC_REQ);

    state_t     r_state;
    logic [6:0] r_sr;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_bc_cnt;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_strobe;
    logic       r_active;

    state_t     w_state_nx;
    logic [2:0] w_bit_cnt_nx;
    logic [3:0] w_bc_cnt_nx;
    logic [7:0] w_data_nx;
    logic       w_valid_nx;
    logic       w_strobe_nx;
    logic [7:0] w_cand;
    logic       w_boundary;
    logic       w_is_comma;

    // The candidate byte always ends with the bit being sampled on this edge.
    assign w_cand     = {r_sr, data_inS};
    assign w_boundary = (r_bit_cnt == 3'd7);
    assign w_is_comma = (w_cand == COMMA);

    always_comb begin
        w_state_nx   = r_state;
        w_bit_cnt_nx = r_bit_cnt + 3'd1;
        w_bc_cnt_nx  = r_bc_cnt;
        w_data_nx    = r_data;
        w_valid_nx   = r_valid;
        w_strobe_nx  = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_is_comma) begin
                    w_bit_cnt_nx = 3'd0;
                    w_bc_cnt_nx  = 4'd1;
                    w_state_nx   = (BC_REQ_L == 4'd1) ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                if (w_boundary) begin
                    if (w_is_comma) begin
                        w_bc_cnt_nx = r_bc_cnt + 4'd1;
                        if (r_bc_cnt + 4'd1 == BC_REQ_L) begin
                            w_state_nx = ACTIVE;
                        end
                    end else begin
                        w_bc_cnt_nx = 4'd0;
                        w_state_nx  = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (w_boundary) begin
                    w_strobe_nx = 1'b1;
                    // Control symbols clear the valid flag but keep the last data visible.
                    if (!w_is_comma && (w_cand != IDLE)) begin
                        w_data_nx  = w_cand;
                        w_valid_nx = 1'b1;
                    end else begin
                        w_valid_nx = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nx = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            r_state   <= SEARCH;
            r_sr      <= 7'd0;
            r_bit_cnt <= 3'd0;
            r_bc_cnt  <= 4'd0;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_strobe  <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_sr      <= {r_sr[5:0], data_inS};
            r_bit_cnt <= w_bit_cnt_nx;
            r_bc_cnt  <= w_bc_cnt_nx;
            r_data    <= w_data_nx;
            r_valid   <= w_valid_nx;
            r_strobe  <= w_strobe_nx;
            r_active  <= (w_state_nx == ACTIVE);
        end
    end

    assign data_outP   = r_data;
    assign valid_out   = r_valid;
    assign byte_strobe = r_strobe;
    assign active      = r_active;
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_serie_paralelo_rx.sv
// Directed bench for serie_paralelo_rx: reset, lock, idle/comma handling,
// mid-stream reset, bit-slip relock and broken preamble, with a byte scoreboard.
module tb_serie_paralelo_rx;

    logic       clk_8f;
    logic       reset;
    logic       data_inS;
    logic [7:0] data_outP;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries are {valid, data}.
    logic [8:0] exp_q[$];
    logic [8:0] shown;

    serie_paralelo_rx dut (
        .clk_8f      (clk_8f),
        .reset       (reset),
        .data_inS    (data_inS),
        .data_outP   (data_outP),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active),
        .state_dbg   (state_dbg)
    );

    initial clk_8f = 1'b0;
    always #5 clk_8f = ~clk_8f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        data_inS = b;
        @(posedge clk_8f);
        #1;
    endtask

    // Sends one byte MSB first. out_exp: a strobe is expected at its last bit.
    // act_exp: expected value of active after the last bit.
    task automatic send_byte(input logic [7:0] b, input bit out_exp, input bit act_exp);
        logic [8:0] e;
        if (out_exp) begin
            if (b != 8'hBC && b != 8'h7C) e = {1'b1, b};
            else                          e = {1'b0, shown[7:0]};
            exp_q.push_back(e);
        end
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            check("strobe", 32'(byte_strobe), 32'(out_exp && i == 0));
            if (i == 0) begin
                check("active", 32'(active), 32'(act_exp));
                if (out_exp) begin
                    if (exp_q.size() == 0) begin
                        check("queue_empty", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_byte", 32'({valid_out, data_outP}), 32'(e));
                        shown = e;
                    end
                end
            end else if (out_exp) begin
                check("hold", 32'({valid_out, data_outP}), 32'(shown));
            end
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            send_bit(i[0] ^ 1'b1);
            check("rst_outs", 32'({data_outP, valid_out, byte_strobe, active}), 32'd0);
            check("rst_state", 32'(state_dbg), 32'd0);
        end
        reset = 1'b0;
        shown = 9'd0;
    endtask

    task automatic preamble(input int n, input bit last_active);
        for (int i = 0; i < n; i++) begin
            send_byte(8'hBC, 1'b0, (i == n - 1) ? last_active : 1'b0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        data_inS = 1'b0;
        shown    = 9'd0;

        // Reset held for three cycles with toggling data.
        do_reset(3);

        // Lock, then data, IDLE, COMMA and data again.
        preamble(4, 1'b1);
        check("lock_state", 32'(state_dbg), 32'd2);
        send_byte(8'hA5, 1'b1, 1'b1);
        send_byte(8'h7C, 1'b1, 1'b1);
        send_byte(8'hBC, 1'b1, 1'b1);
        send_byte(8'h0F, 1'b1, 1'b1);

        // Mid-stream reset four bits into a byte.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        check("mid_strobe", 32'(byte_strobe), 32'd0);
        reset = 1'b1;
        send_bit(1'b0);
        reset = 1'b0;
        shown = 9'd0;
        check("mid_rst_outs", 32'({data_outP, valid_out, active}), 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'd0);

        // Bit-slip: three stray bits, then a full preamble is needed again.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("slip_active", 32'(active), 32'd0);
        preamble(3, 1'b0);
        check("slip_align", 32'(state_dbg), 32'd1);
        send_byte(8'hBC, 1'b0, 1'b1);
        send_byte(8'h3C, 1'b1, 1'b1);

        // Broken preamble returns to SEARCH, then relocks.
        do_reset(1);
        preamble(2, 1'b0);
        send_byte(8'h12, 1'b0, 1'b0);
        check("broken_state", 32'(state_dbg), 32'd0);
        preamble(4, 1'b1);
        send_byte(8'h55, 1'b1, 1'b1);
        send_byte(8'($urandom_range(0, 8'h7B)), 1'b1, 1'b1);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
